// File: rtl/pwm_cycle_updater.sv
// Active PWM period table fed from a host-written shadow table. A commit checks every shadow
// entry in turn, then copies the whole table into CYCLE on the next SYS_TIME epoch boundary.
module pwm_cycle_updater #(
  parameter int WIDTH         = 13,
  parameter int DEPTH         = 249,
  parameter int ADDR_W        = 8,
  parameter int DEFAULT_CYCLE = 4096,
  parameter int MIN_CYCLE     = 2,
  parameter int EPOCH_LOG2    = 18
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [63:0]                 SYS_TIME,
  input  logic                        WE,
  input  logic [ADDR_W-1:0]           ADDR,
  input  logic [WIDTH-1:0]            DIN,
  input  logic                        COMMIT,
  output logic                        BUSY,
  output logic                        DONE,
  output logic                        ERR,
  output logic [ADDR_W-1:0]           ERR_IDX,
  output logic [0:DEPTH-1][WIDTH-1:0] CYCLE
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam int                EPOCH_W   = 64 - EPOCH_LOG2;
  localparam logic [WIDTH-1:0]  DEF_VAL   = WIDTH'(DEFAULT_CYCLE);
  localparam logic [WIDTH-1:0]  MIN_VAL   = WIDTH'(MIN_CYCLE);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic [1:0]                  state_q, state_d;
  logic [ADDR_W-1:0]           idx_q, idx_d;
  logic                        err_q, err_d;
  logic [ADDR_W-1:0]           err_idx_q, err_idx_d;
  logic                        done_q, done_d;
  logic                        apply;
  logic [EPOCH_W-1:0]          epoch_q;
  logic                        epoch_vld_q;
  logic [0:DEPTH-1][WIDTH-1:0] shadow_q;
  logic [0:DEPTH-1][WIDTH-1:0] cycle_q;

  logic [EPOCH_W-1:0] epoch_now;
  logic               boundary;
  logic               wr_ok;
  logic [WIDTH-1:0]   cur_entry;
  logic               unused_low_time;

  assign epoch_now       = SYS_TIME[63:EPOCH_LOG2];
  assign unused_low_time = ^SYS_TIME[EPOCH_LOG2-1:0];
  // Any change of the upper time bits is one boundary, so resync jumps are tolerated.
  assign boundary        = epoch_vld_q && (epoch_now != epoch_q);
  assign BUSY            = (state_q != S_IDLE);
  assign wr_ok           = WE && !BUSY && ({1'b0, ADDR} < DEPTH_EXT);
  assign cur_entry       = shadow_q[idx_q];

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    done_d    = 1'b0;
    apply     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (COMMIT) begin
          state_d = S_CHECK;
          idx_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_CHECK: begin
        if (cur_entry < MIN_VAL) begin
          err_d     = 1'b1;
          err_idx_d = idx_q;
          state_d   = S_IDLE;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_WAIT;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      S_WAIT: begin
        if (boundary) begin
          apply   = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      err_q       <= 1'b0;
      err_idx_q   <= '0;
      done_q      <= 1'b0;
      epoch_q     <= '0;
      epoch_vld_q <= 1'b0;
      // NOTE: both tables are real state visible after reset, so they are reset, not left as RAM.
      shadow_q    <= {DEPTH{DEF_VAL}};
      cycle_q     <= {DEPTH{DEF_VAL}};
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      err_idx_q   <= err_idx_d;
      done_q      <= done_d;
      epoch_q     <= epoch_now;
      epoch_vld_q <= 1'b1;
      if (wr_ok) shadow_q[ADDR] <= DIN;
      if (apply) cycle_q <= shadow_q;
    end
  end

  assign DONE    = done_q;
  assign ERR     = err_q;
  assign ERR_IDX = err_idx_q;
  assign CYCLE   = cycle_q;

endmodule

// File: tb/tb_pwm_cycle_updater.sv
// Scoreboard bench for pwm_cycle_updater with 256-cycle epochs: each commit pushes its expected
// outcome (error index or apply time plus table), popped when BUSY drops.
module tb_pwm_cycle_updater;
  localparam int W  = 13;
  localparam int D  = 249;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [63:0] sys_time = 64'd0;
  logic we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [W-1:0] din = '0;
  logic commit = 1'b0;
  logic busy, done, err;
  logic [AW-1:0] err_idx;
  logic [0:D-1][W-1:0] cycle;

  pwm_cycle_updater #(
    .WIDTH(W), .DEPTH(D), .ADDR_W(AW),
    .DEFAULT_CYCLE(4096), .MIN_CYCLE(2), .EPOCH_LOG2(8)
  ) dut (
    .CLK(clk), .RST(rst), .SYS_TIME(sys_time), .WE(we), .ADDR(addr), .DIN(din),
    .COMMIT(commit), .BUSY(busy), .DONE(done), .ERR(err), .ERR_IDX(err_idx), .CYCLE(cycle)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                  is_err;
    logic [AW-1:0]       idx;
    logic [63:0]         t;
    logic [0:D-1][W-1:0] tbl;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int stray_changes = 0;
  logic [63:0] edge_t;
  logic [0:D-1][W-1:0] shadow_m, active_m, prev_cycle;

  // Expected apply time: first epoch change seen on or after the first WAIT edge.
  function automatic logic [63:0] next_apply(input logic [63:0] tc);
    logic [63:0] t;
    t = tc + 64'd250;
    for (int i = 0; i < 300 && ((t >> 8) == ((t - 64'd1) >> 8)); i++) t = t + 64'd1;
    return t;
  endfunction

  function automatic int first_diff(input logic [0:D-1][W-1:0] a, input logic [0:D-1][W-1:0] b);
    for (int i = 0; i < D; i++) if (a[i] !== b[i]) return i;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    edge_t = sys_time;
    #1;
    sys_time = sys_time + 64'd1;
    if (done === 1'b1) done_cnt++;
    if (!rst && done !== 1'b1 && cycle !== prev_cycle) stray_changes++;
    prev_cycle = cycle;
  endtask

  task automatic write_entry(input logic [AW-1:0] a, input logic [W-1:0] d, input bit accept);
    we = 1'b1; addr = a; din = d;
    tick();
    we = 1'b0;
    if (accept && int'(a) < D) shadow_m[a] = d;
  endtask

  task automatic do_commit(input bit push);
    exp_t e;
    if (push) begin
      e.is_err = 1'b0;
      e.idx    = '0;
      e.tbl    = shadow_m;
      for (int i = D - 1; i >= 0; i--)
        if (shadow_m[i] < 13'd2) begin e.is_err = 1'b1; e.idx = AW'(i); end
      e.t = e.is_err ? sys_time + 64'(e.idx) + 64'd1 : next_apply(sys_time);
      sb.push_back(e);
    end
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output bit got, output logic [63:0] t);
    got = 1'b0;
    t   = '0;
    for (int i = 0; i < limit && !got; i++) begin
      tick();
      if (busy === 1'b0) begin got = 1'b1; t = edge_t; end
    end
  endtask

  task automatic align(input logic [7:0] lo);
    for (int i = 0; i < 300 && sys_time[7:0] != lo; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < D; i++) begin shadow_m[i] = 13'd4096; active_m[i] = 13'd4096; end
    repeat (3) tick();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || err_idx !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_flags: busy=%b done=%b err=%b err_idx=%0d, want 0 0 0 0", busy, done, err, err_idx);
    end
    vectors++;
    if (cycle !== active_m) begin
      miscompares++;
      $display("FAIL reset_table: CYCLE[%0d]=%0d want 4096", first_diff(cycle, active_m), cycle[first_diff(cycle, active_m)]);
    end
    rst = 1'b0;
  endtask

  task automatic test_normal_apply();
    exp_t e; bit got; logic [63:0] t, tc;
    write_entry(8'd248, 13'd4097, 1'b1);
    align(8'h10);
    tc = sys_time;
    do_commit(1'b1);
    wait_idle(700, got, t);
    e = sb.pop_front();
    vectors++;
    if (!got || t !== e.t || done !== 1'b1 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL normal_event: got=%b t=%0h done=%b err=%b, want t=%0h done=1 err=0", got, t, done, err, e.t);
    end
    vectors++;
    if (tc !== 64'h10 || t !== 64'h200 || t - tc < 64'd250) begin
      miscompares++;
      $display("FAIL normal_timing: commit=%0h apply=%0h, want commit=10 apply=200", tc, t);
    end
    vectors++;
    if (cycle !== e.tbl || cycle[248] !== 13'd4097 || cycle[0] !== 13'd4096) begin
      miscompares++;
      $display("FAIL normal_table: CYCLE[%0d]=%0d want %0d", first_diff(cycle, e.tbl), cycle[first_diff(cycle, e.tbl)], e.tbl[first_diff(cycle, e.tbl)]);
    end
    active_m = e.tbl;
    tick();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_width: DONE=%b one cycle after apply, want 0", done);
    end
  endtask

  task automatic test_validation_error();
    exp_t e; bit got; logic [63:0] t, tc; int d0;
    write_entry(8'd17, 13'd1, 1'b1);
    d0 = done_cnt;
    tc = sys_time;
    do_commit(1'b1);
    wait_idle(100, got, t);
    e = sb.pop_front();
    vectors++;
    if (!got || t !== e.t || t !== tc + 64'd18 || err !== 1'b1 || err_idx !== 8'd17) begin
      miscompares++;
      $display("FAIL err_event: got=%b dt=%0d err=%b idx=%0d, want dt=18 err=1 idx=17", got, t - tc, err, err_idx);
    end
    vectors++;
    if (done_cnt !== d0 || cycle !== active_m || cycle[17] !== 13'd4096) begin
      miscompares++;
      $display("FAIL err_no_apply: dones=%0d CYCLE[17]=%0d, want dones=%0d CYCLE[17]=4096", done_cnt, cycle[17], d0);
    end
    // Back-to-back: commit on the cycle right after BUSY fell.
    do_commit(1'b1);
    vectors++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_b2b_accept: busy=%b err=%b, want busy=1 err=0", busy, err);
    end
    wait_idle(100, got, t);
    e = sb.pop_front();
    vectors++;
    if (!got || t !== e.t || err !== 1'b1 || err_idx !== e.idx) begin
      miscompares++;
      $display("FAIL err_b2b_event: got=%b t=%0h err=%b idx=%0d, want t=%0h err=1 idx=%0d", got, t, err, err_idx, e.t, e.idx);
    end
    write_entry(8'd17, 13'd5, 1'b1);
    do_commit(1'b1);
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear: ERR=%b after valid commit, want 0", err);
    end
    wait_idle(700, got, t);
    e = sb.pop_front();
    vectors++;
    if (!got || t !== e.t || done !== 1'b1 || err !== 1'b0 || cycle !== e.tbl) begin
      miscompares++;
      $display("FAIL err_recover: got=%b t=%0h done=%b err=%b CYCLE[17]=%0d, want t=%0h done=1 err=0 CYCLE[17]=5", got, t, done, err, cycle[17], e.t);
    end
    active_m = e.tbl;
  endtask

  task automatic test_boundary_in_check();
    exp_t e; bit got; logic [63:0] t, tc;
    align(8'h80);
    tc = sys_time;
    // Write and commit on the same edge: the write must be part of the checked table.
    we = 1'b1; addr = 8'd200; din = 13'd1234;
    shadow_m[200] = 13'd1234;
    do_commit(1'b1);
    we = 1'b0;
    wait_idle(700, got, t);
    e = sb.pop_front();
    vectors++;
    if (!got || t !== e.t || t !== tc + 64'h180 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL bnd_in_check: got=%b dt=%0h done=%b, want dt=180 done=1", got, t - tc, done);
    end
    vectors++;
    if (cycle !== e.tbl || cycle[200] !== 13'd1234) begin
      miscompares++;
      $display("FAIL bnd_table: CYCLE[200]=%0d want 1234", cycle[200]);
    end
    active_m = e.tbl;
  endtask

  task automatic test_ignored_inputs();
    exp_t e; bit got; logic [63:0] t; int d0;
    write_entry(8'd250, 13'd55, 1'b0);
    align(8'h08);
    d0 = done_cnt;
    do_commit(1'b1);
    repeat (3) tick();
    write_entry(8'd5, 13'd7, 1'b0);
    write_entry(8'd250, 13'd9, 1'b0);
    repeat (100) tick();
    do_commit(1'b0);
    repeat (190) tick();
    do_commit(1'b0);
    wait_idle(700, got, t);
    e = sb.pop_front();
    vectors++;
    if (!got || t !== e.t || done !== 1'b1 || cycle !== e.tbl || cycle[5] !== 13'd4096) begin
      miscompares++;
      $display("FAIL ign_apply: got=%b t=%0h done=%b CYCLE[5]=%0d, want t=%0h done=1 CYCLE[5]=4096", got, t, done, cycle[5], e.t);
    end
    active_m = e.tbl;
    repeat (20) tick();
    vectors++;
    if (busy !== 1'b0 || done_cnt !== d0 + 1) begin
      miscompares++;
      $display("FAIL ign_single_done: busy=%b dones=%0d, want busy=0 dones=%0d", busy, done_cnt - d0, 1);
    end
    // Re-apply the untouched shadow: a leaked busy-time write would show up here.
    do_commit(1'b1);
    wait_idle(700, got, t);
    e = sb.pop_front();
    vectors++;
    if (!got || t !== e.t || cycle !== e.tbl) begin
      miscompares++;
      $display("FAIL ign_shadow: got=%b CYCLE[5]=%0d, want 4096", got, cycle[5]);
    end
    active_m = e.tbl;
  endtask

  task automatic test_reset_mid_and_jump();
    exp_t e; bit got; logic [63:0] t; int d0;
    write_entry(8'd3, 13'd100, 1'b1);
    align(8'h01);
    d0 = done_cnt;
    do_commit(1'b1);
    repeat (251) tick();
    vectors++;
    if (busy !== 1'b1 || done_cnt !== d0) begin
      miscompares++;
      $display("FAIL rst_pre_wait: busy=%b dones=%0d, want busy=1 dones=0", busy, done_cnt - d0);
    end
    rst = 1'b1;
    repeat (2) tick();
    e = sb.pop_front();
    for (int i = 0; i < D; i++) begin shadow_m[i] = 13'd4096; active_m[i] = 13'd4096; end
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || cycle !== active_m) begin
      miscompares++;
      $display("FAIL rst_mid: busy=%b done=%b err=%b CYCLE[3]=%0d, want 0 0 0 4096", busy, done, err, cycle[3]);
    end
    rst = 1'b0;
    do_commit(1'b1);
    wait_idle(700, got, t);
    e = sb.pop_front();
    vectors++;
    if (!got || t !== e.t || done !== 1'b1 || cycle !== e.tbl) begin
      miscompares++;
      $display("FAIL rst_shadow: got=%b t=%0h CYCLE[3]=%0d, want t=%0h CYCLE[3]=4096", got, t, cycle[3], e.t);
    end
    active_m = e.tbl;

    write_entry(8'd100, 13'd777, 1'b1);
    align(8'h01);
    do_commit(1'b0);
    repeat (251) tick();
    sys_time = sys_time + 64'h1000;
    e.is_err = 1'b0; e.idx = '0; e.t = sys_time; e.tbl = shadow_m;
    sb.push_back(e);
    wait_idle(10, got, t);
    e = sb.pop_front();
    vectors++;
    if (!got || t !== e.t || done !== 1'b1 || cycle !== e.tbl || cycle[100] !== 13'd777) begin
      miscompares++;
      $display("FAIL jump_apply: got=%b t=%0h done=%b CYCLE[100]=%0d, want t=%0h done=1 CYCLE[100]=777", got, t, done, cycle[100], e.t);
    end
    active_m = e.tbl;
  endtask

  initial begin
    test_reset();
    test_normal_apply();
    test_validation_error();
    test_boundary_in_check();
    test_ignored_inputs();
    test_reset_mid_and_jump();
    vectors++;
    if (stray_changes !== 0 || cycle !== active_m) begin
      miscompares++;
      $display("FAIL table_stability: changes without DONE=%0d, want 0", stray_changes);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
